// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register-file write port arbiter between GSU core and SNES host
// Host byte writes assemble into a pending word that is committed when the core is idle or starved too long.
module reg_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int GO_REG       = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_we,
    input  logic [3:0]  core_sel,
    input  logic [15:0] core_data,
    output logic        core_stall,
    input  logic        host_wr,
    input  logic [4:0]  host_addr,
    input  logic [7:0]  host_data,
    output logic        host_busy,
    output logic        host_overrun,
    output logic [15:0] reg_we,
    output logic [15:0] reg_wdata,
    output logic        gsu_go
);
    typedef enum logic {IDLE, HOST_PEND} state_t;

    localparam logic [2:0] LIMIT  = 3'(STARVE_LIMIT);
    localparam logic [3:0] GO_SEL = 4'(GO_REG);

    state_t      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  lo_latch_q, lo_latch_d;
    logic [15:0] pend_word_q, pend_word_d;
    logic [3:0]  pend_sel_q, pend_sel_d;
    logic [15:0] reg_we_q, reg_we_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        gsu_go_q, gsu_go_d;
    logic        overrun_q, overrun_d;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        lo_latch_d  = lo_latch_q;
        pend_word_d = pend_word_q;
        pend_sel_d  = pend_sel_q;
        overrun_d   = overrun_q;
        reg_we_d    = 16'h0000;
        reg_wdata_d = 16'h0000;
        gsu_go_d    = 1'b0;
        core_stall  = (state_q == HOST_PEND) && (wait_cnt_q == LIMIT);

        if (state_q == IDLE) begin
            if (core_we) begin
                reg_we_d    = 16'h0001 << core_sel;
                reg_wdata_d = core_data;
            end
        end else begin
            if (core_we && !core_stall) begin
                reg_we_d    = 16'h0001 << core_sel;
                reg_wdata_d = core_data;
                // Cannot exceed LIMIT: this branch only runs while wait_cnt_q < LIMIT.
                wait_cnt_d  = wait_cnt_q + 3'd1;
            end else begin
                reg_we_d    = 16'h0001 << pend_sel_q;
                reg_wdata_d = pend_word_q;
                gsu_go_d    = (pend_sel_q == GO_SEL);
                state_d     = IDLE;
            end
        end

        // Decisions above use the pre-capture state, so a capture never commits in its own cycle.
        if (host_wr) begin
            if (!host_addr[0]) begin
                lo_latch_d = host_data;
            end else if (state_q == HOST_PEND) begin
                overrun_d = 1'b1;
            end else begin
                pend_word_d = {host_data, lo_latch_q};
                pend_sel_d  = host_addr[4:1];
                wait_cnt_d  = 3'd0;
                state_d     = HOST_PEND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 3'd0;
            lo_latch_q  <= 8'h00;
            pend_word_q <= 16'h0000;
            pend_sel_q  <= 4'h0;
            reg_we_q    <= 16'h0000;
            reg_wdata_q <= 16'h0000;
            gsu_go_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            lo_latch_q  <= lo_latch_d;
            pend_word_q <= pend_word_d;
            pend_sel_q  <= pend_sel_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            gsu_go_q    <= gsu_go_d;
            overrun_q   <= overrun_d;
        end
    end

    assign host_busy    = (state_q == HOST_PEND);
    assign host_overrun = overrun_q;
    assign reg_we       = reg_we_q;
    assign reg_wdata    = reg_wdata_q;
    assign gsu_go       = gsu_go_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed bench with a behavioural write-port model for reg_write_arbiter
module tb_reg_write_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_we;
    logic [3:0]  core_sel;
    logic [15:0] core_data;
    logic        core_stall;
    logic        host_wr;
    logic [4:0]  host_addr;
    logic [7:0]  host_data;
    logic        host_busy;
    logic        host_overrun;
    logic [15:0] reg_we;
    logic [15:0] reg_wdata;
    logic        gsu_go;

    reg_write_arbiter #(.STARVE_LIMIT(LIMIT), .GO_REG(15)) dut (
        .clk(clk), .reset(reset),
        .core_we(core_we), .core_sel(core_sel), .core_data(core_data), .core_stall(core_stall),
        .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
        .host_busy(host_busy), .host_overrun(host_overrun),
        .reg_we(reg_we), .reg_wdata(reg_wdata), .gsu_go(gsu_go)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Model state: what the host has handed over and what the write port must show next.
    bit          m_pending = 0;
    int          m_waits   = 0;
    int          m_psel    = 0;
    int          m_pword   = 0;
    int          m_lo      = 0;
    bit          m_ovr     = 0;
    int          e_we      = 0;
    int          e_wdata   = 0;
    bit          e_go      = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit was_pending;
        bit starved;
        was_pending = m_pending;
        if (reset) begin
            m_pending = 0; m_waits = 0; m_lo = 0; m_ovr = 0;
            e_we = 0; e_wdata = 0; e_go = 0;
            return;
        end
        starved = m_pending && (m_waits == LIMIT);
        e_we = 0; e_wdata = 0; e_go = 0;
        if (m_pending && (starved || !core_we)) begin
            e_we = 1 << m_psel; e_wdata = m_pword; e_go = (m_psel == 15);
            m_pending = 0;
        end else if (core_we) begin
            e_we = 1 << int'(core_sel); e_wdata = int'(core_data);
            if (m_pending) m_waits++;
        end
        if (host_wr) begin
            if (host_addr[0] == 1'b0) m_lo = int'(host_data);
            else if (was_pending) m_ovr = 1;
            else begin
                m_pending = 1; m_waits = 0;
                m_psel  = int'(host_addr[4:1]);
                m_pword = int'(host_data) * 256 + m_lo;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("reg_we", reg_we, 16'(e_we));
            if (e_we != 0) check("reg_wdata", reg_wdata, 16'(e_wdata));
            check("gsu_go", {15'd0, gsu_go}, {15'd0, e_go});
            check("host_busy", {15'd0, host_busy}, {15'd0, m_pending});
            check("host_overrun", {15'd0, host_overrun}, {15'd0, m_ovr});
            check("core_stall", {15'd0, core_stall},
                  {15'd0, (m_pending && m_waits == LIMIT)});
        end
    end

    task automatic drive(input bit rst, input bit cwe, input logic [3:0] csel,
                         input logic [15:0] cdat, input bit hwr,
                         input logic [4:0] haddr, input logic [7:0] hdat);
        @(negedge clk);
        #1;
        reset = rst; core_we = cwe; core_sel = csel; core_data = cdat;
        host_wr = hwr; host_addr = haddr; host_data = hdat;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step(input bit rst, input bit cwe, input logic [3:0] csel,
                        input logic [15:0] cdat, input bit hwr,
                        input logic [4:0] haddr, input logic [7:0] hdat);
        drive(rst, cwe, csel, cdat, hwr, haddr, hdat);
        tick();
    endtask

    initial begin
        reset = 1; core_we = 0; core_sel = 0; core_data = 0;
        host_wr = 0; host_addr = 0; host_data = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        check("rst_we", reg_we, 16'h0000);
        check("rst_wdata", reg_wdata, 16'h0000);
        check("rst_flags", {13'd0, gsu_go, host_busy, host_overrun}, 16'h0000);

        // 1: plain core write
        step(0, 1, 4'd3, 16'hBEEF, 0, 0, 0);
        check("t1_we", reg_we, 16'h0008);
        check("t1_wdata", reg_wdata, 16'hBEEF);
        check("t1_go", {15'd0, gsu_go}, 16'h0000);

        // 2: host word to R5 with idle core
        step(0, 0, 0, 0, 1, 5'h0A, 8'h34);
        step(0, 0, 0, 0, 1, 5'h0B, 8'h12);
        check("t2_busy", {15'd0, host_busy}, 16'h0001);
        check("t2_we_early", reg_we, 16'h0000);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t2_we", reg_we, 16'h0020);
        check("t2_wdata", reg_wdata, 16'h1234);
        check("t2_busy_drop", {15'd0, host_busy}, 16'h0000);

        // 3: core hammers the port while host R7 waits
        step(0, 0, 0, 0, 1, 5'h0F, 8'hAA);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 4'd1, 16'h1000 + 16'(i), 0, 0, 0);
            if (i == 4) check("t3_stall", {15'd0, core_stall}, 16'h0001);
            else check("t3_nostall", {15'd0, core_stall}, 16'h0000);
            tick();
            if (i == 4) begin
                check("t3_host_we", reg_we, 16'h0080);
                check("t3_host_wdata", reg_wdata, 16'hAA34);
            end else begin
                check("t3_core_we", reg_we, 16'h0002);
                check("t3_core_wdata", reg_wdata, 16'h1000 + 16'(i));
            end
        end

        // 4: host commit of R15 starts the core; core write to R15 does not
        step(0, 0, 0, 0, 1, 5'h1E, 8'h00);
        step(0, 0, 0, 0, 1, 5'h1F, 8'h80);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t4_we", reg_we, 16'h8000);
        check("t4_wdata", reg_wdata, 16'h8000);
        check("t4_go", {15'd0, gsu_go}, 16'h0001);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t4_go_pulse", {15'd0, gsu_go}, 16'h0000);
        step(0, 1, 4'd15, 16'h1234, 0, 0, 0);
        check("t4_core_we", reg_we, 16'h8000);
        check("t4_core_go", {15'd0, gsu_go}, 16'h0000);

        // 5: overrun while busy, alongside a core write
        step(0, 0, 0, 0, 1, 5'h05, 8'h56);
        step(0, 1, 4'd4, 16'h4444, 1, 5'h07, 8'h99);
        check("t5_ovr", {15'd0, host_overrun}, 16'h0001);
        check("t5_core_we", reg_we, 16'h0010);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t5_host_we", reg_we, 16'h0004);
        check("t5_host_wdata", reg_wdata, 16'h5600);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t5_ovr_sticky", {15'd0, host_overrun}, 16'h0001);

        // 6: reset discards a pending R15 word
        step(0, 0, 0, 0, 1, 5'h1F, 8'h80);
        step(1, 0, 0, 0, 0, 0, 0);
        check("t6_flags", {13'd0, gsu_go, host_busy, host_overrun}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("t6_we", reg_we, 16'h0000);
            check("t6_go", {15'd0, gsu_go}, 16'h0000);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
